// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
package approx_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 17;
  localparam int MAX_W     = 32;

  // Wide enough for any supported operand width; callers zero-extend and slice.
  function automatic logic [MAX_W:0] abs_diff(input logic [MAX_W:0] x,
                                              input logic [MAX_W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_ref_adder.sv
// Exact reference sum and error distance for one (a, b, sum) triple.
module approx_ref_adder
  import approx_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int FULL_REF = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] sum,
  output logic [W:0]   ref_sum,
  output logic [W:0]   sum_ext,
  output logic [W:0]   ed
);

  logic [W:0]     full;
  logic [MAX_W:0] diff;
  logic           unused_hi;

  always_comb begin
    full    = {1'b0, a} + {1'b0, b};
    ref_sum = (FULL_REF != 0) ? full : {1'b0, full[W-1:0]};
    sum_ext = {1'b0, sum};
    // True magnitude of the difference, not a modular distance.
    diff    = abs_diff((MAX_W+1)'(ref_sum), (MAX_W+1)'(sum_ext));
    ed      = diff[W:0];
  end

  assign unused_hi = ^diff[MAX_W:W+1];

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-metric collector for an approximate adder: 2-stage pipeline plus run FSM.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int FULL_REF = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [W-1:0]         in_sum,
  input  logic                 in_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W+W:0]     ed_sum,
  output logic [W:0]           ed_max,
  output logic                 sat
);

  localparam int ES_W = CNT_W + W + 1;

  state_t          state;
  logic            accept;
  logic            clear;
  logic [W:0]      ref_c, sum_c, ed_c;
  logic [W:0]      ref_p1, sum_p1, ed_p1;
  logic            vld_p1;
  logic [CNT_W:0]  samp_nxt, err_nxt;
  logic [ES_W:0]   esum_nxt;

  // Returns {overflow_attempted, new_value}; clamps at all-ones.
  function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] x, input logic en);
    if (!en)
      return {1'b0, x};
    if (&x)
      return {1'b1, x};
    return {1'b0, x + 1'b1};
  endfunction

  function automatic logic [ES_W:0] acc_add(input logic [ES_W-1:0] x, input logic [W:0] d);
    logic [ES_W:0] t;
    t = {1'b0, x} + (ES_W+1)'(d);
    if (t[ES_W])
      return {1'b1, {ES_W{1'b1}}};
    return t;
  endfunction

  assign accept = in_valid && in_ready;
  assign clear  = start && (state != DRAIN);

  approx_ref_adder #(.W(W), .FULL_REF(FULL_REF)) u_ref (
    .a       (in_a),
    .b       (in_b),
    .sum     (in_sum),
    .ref_sum (ref_c),
    .sum_ext (sum_c),
    .ed      (ed_c)
  );

  // Stage 1: reference, extended sum and error distance
  always_ff @(posedge clk) begin
    if (accept) begin
      ref_p1 <= ref_c;
      sum_p1 <= sum_c;
      ed_p1  <= ed_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      // A start in the same cycle as a transfer drops that triple.
      vld_p1 <= accept && !start;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        RUN: if (!start && accept && in_last) begin
          state    <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (!vld_p1) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: if (start) begin
          state    <= RUN;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    samp_nxt = cnt_inc(sample_cnt, 1'b1);
    err_nxt  = cnt_inc(err_cnt, ref_p1 != sum_p1);
    esum_nxt = acc_add(ed_sum, ed_p1);
  end

  // Stage 2: metric accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sat        <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sat        <= 1'b0;
    end else if (vld_p1) begin
      sample_cnt <= samp_nxt[CNT_W-1:0];
      err_cnt    <= err_nxt[CNT_W-1:0];
      ed_sum     <= esum_nxt[ES_W-1:0];
      ed_max     <= (ed_p1 > ed_max) ? ed_p1 : ed_max;
      sat        <= sat | samp_nxt[CNT_W] | err_nxt[CNT_W] | esum_nxt[ES_W];
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor: modular, full-width and narrow-counter variants.
module tb_approx_err_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_a = '0, in_b = '0, in_sum = '0;

  logic        rdy0, busy0, done0, sat0;
  logic [16:0] samp0, err0;
  logic [25:0] esum0;
  logic [8:0]  emax0;
  logic        rdy1, busy1, done1, sat1;
  logic [16:0] samp1, err1;
  logic [25:0] esum1;
  logic [8:0]  emax1;
  logic        rdy2, busy2, done2, sat2;
  logic [2:0]  samp2, err2;
  logic [11:0] esum2;
  logic [8:0]  emax2;

  approx_err_monitor #(.W(8), .CNT_W(17), .FULL_REF(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_last(in_last),
    .busy(busy0), .done(done0), .sample_cnt(samp0), .err_cnt(err0),
    .ed_sum(esum0), .ed_max(emax0), .sat(sat0));

  approx_err_monitor #(.W(8), .CNT_W(17), .FULL_REF(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_last(in_last),
    .busy(busy1), .done(done1), .sample_cnt(samp1), .err_cnt(err1),
    .ed_sum(esum1), .ed_max(emax1), .sat(sat1));

  approx_err_monitor #(.W(8), .CNT_W(3), .FULL_REF(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_last(in_last),
    .busy(busy2), .done(done2), .sample_cnt(samp2), .err_cnt(err2),
    .ed_sum(esum2), .ed_max(emax2), .sat(sat2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    int     samp;
    int     errc;
    longint esum;
    int     emax;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     m_samp = 0, m_err = 0, m_max = 0;
  longint m_sum = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_ed(input int a, input int b, input int s, input bit full);
    int r;
    r = full ? (a + b) : ((a + b) % 256);
    return (r > s) ? (r - s) : (s - r);
  endfunction

  task automatic model_clear();
    m_samp = 0; m_err = 0; m_sum = 0; m_max = 0;
  endtask

  // Drive one cycle at a negedge; predict dut0 metrics two edges after a transfer.
  task automatic step(input bit v, input int a, input int b, input int s,
                      input bit l, input bit st);
    int e;
    in_valid = v;
    in_a     = a[7:0];
    in_b     = b[7:0];
    in_sum   = s[7:0];
    in_last  = l;
    start    = st;
    if (st && !(busy0 && !rdy0)) begin
      model_clear();
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      sb.push_back('{cyc + 1, 0, 0, 0, 0});
    end else if (v && rdy0) begin
      e = model_ed(a, b, s, 1'b0);
      m_samp++;
      if (e != 0) m_err++;
      m_sum += e;
      if (e > m_max) m_max = e;
      sb.push_back('{cyc + 2, m_samp, m_err, m_sum, m_max});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after the last triple's accepting edge.
  task automatic end_check(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk({tag, "_done_early"}, done0, 0);
    chk({tag, "_busy_drain"}, busy0, 1);
    @(negedge clk);
    chk({tag, "_done0"}, done0, 1);
    chk({tag, "_done1"}, done1, 1);
    chk({tag, "_done2"}, done2, 1);
    chk({tag, "_busy_end"}, busy0, 0);
    chk({tag, "_ready_end"}, rdy0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("sb_sample_cnt", samp0, e.samp);
      chk("sb_err_cnt", err0, e.errc);
      chk("sb_ed_sum", esum0, e.esum);
      chk("sb_ed_max", emax0, e.emax);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_samp", samp0, 0);
    chk("rst_err", err0, 0);
    chk("rst_esum", esum0, 0);
    chk("rst_emax", emax0, 0);
    chk("rst_ready1", rdy1, 0);
    chk("rst_ready2", rdy2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Exhaustive sweep with an exact adder
    step(0, 0, 0, 0, 0, 1);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        step(1, a, b, (a + b) % 256, (a == 255) && (b == 255), 0);
    end_check("sweep");
    chk("sweep_samp", samp0, 65536);
    chk("sweep_err", err0, 0);
    chk("sweep_esum", esum0, 0);
    chk("sweep_emax", emax0, 0);
    chk("sweep_sat0", sat0, 0);
    chk("sweep_samp1", samp1, 65536);
    chk("sweep_samp2_clamped", samp2, 7);
    chk("sweep_sat2", sat2, 1);

    // Directed triples, modular and full-width reference
    step(0, 0, 0, 0, 0, 1);
    step(1, 10, 20, 30, 0, 0);
    step(1, 200, 100, 44, 0, 0);
    step(1, 1, 0, 255, 1, 0);
    end_check("dir");
    chk("dir_samp0", samp0, 3);
    chk("dir_err0", err0, 1);
    chk("dir_esum0", esum0, 254);
    chk("dir_emax0", emax0, 254);
    chk("dir_err1", err1, 2);
    chk("dir_esum1", esum1, 510);
    chk("dir_emax1", emax1, 256);

    // Random gaps with a start coincident with a valid triple
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0);
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           i == 39, i == 20);
    end
    end_check("rnd");
    chk("rnd_samp", samp0, 19);
    chk("rnd_err_model", err0, m_err);
    chk("rnd_esum_model", esum0, m_sum);

    // Narrow counters saturate without wrapping
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, i == 9, 0);
    end_check("satr");
    chk("sat_err2", err2, 7);
    chk("sat_samp2", samp2, 7);
    chk("sat_flag2", sat2, 1);
    chk("sat_esum2", esum2, 20);
    chk("sat_emax2", emax2, 2);
    chk("sat_samp0", samp0, 10);
    step(0, 0, 0, 0, 0, 1);
    chk("sat_cleared", sat2, 0);
    chk("sat_samp2_cleared", samp2, 0);

    // Asynchronous reset while draining
    step(1, 5, 5, 0, 0, 0);
    step(1, 3, 4, 7, 0, 0);
    step(1, 9, 9, 1, 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("drn_samp_pre", samp0, 3);
    rst = 1'b1;
    #1;
    sb.delete();
    model_clear();
    chk("drn_done", done0, 0);
    chk("drn_busy", busy0, 0);
    chk("drn_ready", rdy0, 0);
    chk("drn_samp", samp0, 0);
    chk("drn_err", err0, 0);
    chk("drn_esum", esum0, 0);
    chk("drn_emax", emax0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("drn_idle_done", done0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 7, 8, 15, 0, 0);
    step(1, 100, 100, 0, 0, 0);
    step(1, 255, 1, 3, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    end_check("fresh");
    chk("fresh_samp", samp0, 4);
    chk("fresh_err", err0, 2);
    chk("fresh_esum", esum0, 203);
    chk("fresh_emax", emax0, 200);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Streaming error-metric collector that consumes (a, b, sum) triples produced by an approximate adder under test, for example adder8_8.
- Computes the exact reference sum in hardware and accumulates error rate, total error distance and maximum error distance over one run.
- Sits downstream of the adder and replaces off-line post-processing of dumped result files, so exhaustive 256x256 sweeps are graded on-chip or in simulation.

Parameters:
- W, 8, operand and sum width.
- CNT_W, 17, width of the sample and error counters (2^16 pairs plus headroom).
- FULL_REF, 0: if 0, the reference is (a+b) mod 2^W; if 1, the reference is the W+1-bit a+b, and sum is zero-extended before comparison.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears metrics and begins a run.
- in_valid  in  1  triple valid.
- in_ready  out  1  monitor accepts triple.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sum  in  W  approximate sum from the DUT.
- in_last  in  1  marks the final triple of the run.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  metrics final; held high until the next start.
- sample_cnt  out  CNT_W  triples accepted.
- err_cnt  out  CNT_W  triples with nonzero error distance.
- ed_sum  out  CNT_W+W+1  sum of |ref - sum|.
- ed_max  out  W+1  largest |ref - sum| seen.
- sat  out  1  sticky; some counter saturated.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. in_ready, busy, done and sat are 0. All metric outputs are 0.
- Transfer: a triple is accepted when in_valid && in_ready. in_ready = 1 only in RUN. Upstream must hold the triple stable while in_valid=1 and in_ready=0.
- State IDLE:
  - start -> RUN and all metrics cleared in the same cycle.
- State RUN:
  - Accepted triple with in_last=1 -> DRAIN.
  - start -> metrics cleared, stay in RUN; any in-flight triple is discarded.
- State DRAIN:
  - in_ready=0. Wait until both pipeline stages are empty, at most 2 cycles, then -> DONE.
  - start is ignored.
- State DONE:
  - done=1, metrics frozen.
  - start -> clear metrics and done, -> RUN.
- Pipeline, 2 stages:
  - Stage 1 registers ref, the zero-extended sum and ed = |ref - sum| as W+1 bits.
  - Stage 2 updates the metrics: sample_cnt += 1; err_cnt += (ed != 0); ed_sum += ed; ed_max = max(ed_max, ed).
  - Metrics reflect an accepted triple exactly 2 cycles after acceptance. done rises on the cycle after the last triple's stage-2 update, i.e. 3 cycles after in_last is accepted.
- Width rules:
  - With FULL_REF=0, ed is still computed as an unsigned W-bit difference magnitude, e.g. ref=0x01, sum=0xFF -> ed=254. No modular shortcut.
  - sample_cnt, err_cnt and ed_sum saturate at all-ones and never wrap. The first saturation sets sat, which stays set until start or rst.
- Throughput: one triple per cycle in RUN, with no bubbles required.
- Simultaneous start and accepted triple in RUN: start wins and the triple is dropped, not counted.
- in_last with no prior triples counts normally as a 1-sample run.
- rst mid-RUN: everything returns to reset values immediately and the pipeline is flushed.

Decomposition:
- Shared package approx_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Default W and CNT_W localparams.
  - Function abs_diff(W+1, W+1).
- One natural sub-module, approx_ref_adder: combinational exact reference plus error-distance stage, instantiated in stage 1.
- Accumulator logic and the FSM stay in the top module.

Test Plan:
- Exact DUT model (sum = a+b mod 256), all 65536 pairs, last on (255,255) -> sample_cnt=65536, err_cnt=0, ed_sum=0, ed_max=0; done 3 cycles after the last accept.
- Directed triples (10,20,30), (200,100,44), (1,0,255) with FULL_REF=0 -> err_cnt=1, ed_sum=254, ed_max=254.
- Same triples with FULL_REF=1 -> (200,100,44) gives ed=256, (1,0,255) gives ed=254; err_cnt=2, ed_sum=510, ed_max=256.
- Random in_valid gaps at 50% and a start pulse coincident with a valid triple mid-run -> the coincident triple is not counted; the remaining totals match the scoreboard.
- CNT_W=3, 10 error triples -> err_cnt=7, sample_cnt=7, sat=1, no wrap; the next start clears sat.
- rst asserted 2 cycles after in_last is accepted (in DRAIN) -> done=0 and all metrics 0 the same cycle; a fresh start runs normally.
